// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
//   Shared types and helpers for the MLP layer sequencer.
//   - fp_t       : default signed fixed-point word (Q8.8 by default).
//   - state_t    : sequencer FSM states.
//   - class_w()  : width of a class index, clog2 with a floor of 1 (CLASS_W).
//   - layer_w()  : width of a layer index, clog2 with a floor of 1 (LAYER_W).
//   - relu()     : max(x, 0) on an fp_t word.
// -----------------------------------------------------------------------------
package mlp_pkg;

  localparam int FP_BITS_DEFAULT = 16;

  typedef logic signed [FP_BITS_DEFAULT-1:0] fp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    ARGMAX  = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  // clog2 that never returns 0, so a single-entry index still has one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int class_w(input int num_classes);
    return clog2_min1(num_classes);
  endfunction

  function automatic int layer_w(input int num_layers);
    return clog2_min1(num_layers);
  endfunction

  function automatic fp_t relu(input fp_t x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/mlp_argmax_seq.sv
// -----------------------------------------------------------------------------
// mlp_argmax_seq
//   Iterative signed argmax, one comparison per cycle.
//   A start pulse seeds the running best with lane 0 (start_val) and begins
//   comparing lanes 1..NUM_CLASSES-1 of `scores`, which must be held stable
//   until done. Strict greater-than keeps the lowest index on ties.
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start        one-cycle pulse: seed best with start_val, idx 0
//   start_val    value of lane 0 at the start pulse
//   scores       lanes to compare (held stable while comparing)
//   done         high during the cycle that performs the final compare
//   best_idx     running / final argmax index (registered)
// -----------------------------------------------------------------------------
module mlp_argmax_seq
  import mlp_pkg::*;
#(
  parameter int NUM_CLASSES   = 3,
  parameter int FP_TOTAL_BITS = 16,
  localparam int CLASS_W      = class_w(NUM_CLASSES)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [FP_TOTAL_BITS-1:0]                   start_val,
  input  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]  scores,
  output logic                                       done,
  output logic [CLASS_W-1:0]                         best_idx
);

  logic                     active;
  logic [CLASS_W-1:0]       cmp_idx;
  logic [FP_TOTAL_BITS-1:0] best_val;
  logic [FP_TOTAL_BITS-1:0] cand;

  assign cand = scores[cmp_idx];
  assign done = active && (cmp_idx == CLASS_W'(NUM_CLASSES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      cmp_idx  <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (start) begin
      best_idx <= '0;
      best_val <= start_val;
      cmp_idx  <= CLASS_W'(1);
      // A single class has nothing to compare against.
      active   <= (NUM_CLASSES > 1);
    end else if (active) begin
      if ($signed(cand) > $signed(best_val)) begin
        best_idx <= cmp_idx;
        best_val <= cand;
      end
      if (done) begin
        active <= 1'b0;
      end else begin
        cmp_idx <= cmp_idx + CLASS_W'(1);
      end
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//   Runs one inference through NUM_LAYERS layers on a single shared layer
//   datapath. For each layer: present layer_sel/layer_x, pulse layer_start,
//   wait for a fresh layer_done, then ReLU the outputs back into layer_x.
//   After the last layer the raw scores are latched and an iterative signed
//   argmax picks the class.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
//   high at the rising clock edge. in_ready depends only on state (IDLE or
//   ERROR) and reset; once out_valid rises, out_valid/out_scores/out_class hold
//   until the cycle out_ready is high. in_ready is 0 in DONE, so an input can
//   never be taken in the same cycle an output is consumed.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   in_valid/in_ready/in_x          feature vector input
//   out_valid/out_ready             result handshake
//   out_scores     final-layer raw outputs (no ReLU)
//   out_class      argmax index (ties -> lowest index)
//   error          sticky timeout flag, cleared by the next accepted input
//   busy           inference in progress
//   layer_start    one-cycle start pulse to the datapath
//   layer_sel      active layer (selects the weight/bias bank)
//   layer_x        datapath input vector (registered)
//   layer_out      datapath outputs
//   layer_done     datapath completion
//   dbg_state      current FSM state
// -----------------------------------------------------------------------------
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_FEATURES   = 4,
  parameter int FP_TOTAL_BITS  = 16,
  parameter int FP_FRAC_BITS   = 8,
  parameter int NUM_CLASSES    = 3,
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CLASS_W       = class_w(NUM_CLASSES),
  localparam int LAYER_W       = layer_w(NUM_LAYERS)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]  in_x,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]   out_scores,
  output logic [CLASS_W-1:0]                          out_class,
  output logic                                        error,
  output logic                                        busy,
  output logic                                        layer_start,
  output logic [LAYER_W-1:0]                          layer_sel,
  output logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]  layer_x,
  input  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]   layer_out,
  input  logic                                        layer_done,
  output state_t                                      dbg_state
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

  // Parameter sanity; the fraction width is informational but must fit.
  if (NUM_FEATURES < NUM_CLASSES || NUM_LAYERS < 1 ||
      FP_FRAC_BITS >= FP_TOTAL_BITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mlp_layer_sequencer: illegal parameter combination");
  end

  state_t                                       state;
  logic [CNT_W-1:0]                             wait_cnt;
  logic                                         armed;
  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   relu_vec;
  logic                                         last_layer;
  logic                                         am_start;
  logic                                         am_done;
  logic [CLASS_W-1:0]                           am_best_idx;

  assign dbg_state  = state;
  assign in_ready   = reset && ((state == IDLE) || (state == ERROR));
  assign last_layer = (layer_sel == LAYER_W'(NUM_LAYERS - 1));
  assign am_start   = (state == CAPTURE) && last_layer;
  assign out_class  = am_best_idx;

  // ReLU of the datapath outputs; lanes beyond NUM_CLASSES feed zeros.
  always_comb begin
    relu_vec = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      relu_vec[i] = layer_out[i][FP_TOTAL_BITS-1] ? '0 : layer_out[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      layer_x     <= '0;
      layer_sel   <= '0;
      layer_start <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      out_valid   <= 1'b0;
      out_scores  <= '0;
      wait_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      // layer_start is only ever high for the single START cycle.
      layer_start <= 1'b0;
      unique case (state)
        IDLE, ERROR: begin
          if (in_valid) begin
            layer_x     <= in_x;
            layer_sel   <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            layer_start <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          armed    <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // Completion needs done to be seen low first, so a done still high
          // from the previous layer cannot complete this one.
          if (!layer_done) begin
            armed <= 1'b1;
          end
          if (armed && layer_done) begin
            state <= CAPTURE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERROR;
          end
        end
        CAPTURE: begin
          if (!last_layer) begin
            layer_x     <= relu_vec;
            layer_sel   <= layer_sel + LAYER_W'(1);
            layer_start <= 1'b1;
            state       <= START;
          end else begin
            // Final layer: raw scores, no ReLU. Argmax seeds from layer_out[0].
            out_scores <= layer_out;
            if (NUM_CLASSES == 1) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ARGMAX;
            end
          end
        end
        ARGMAX: begin
          if (am_done) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mlp_argmax_seq #(
    .NUM_CLASSES   (NUM_CLASSES),
    .FP_TOTAL_BITS (FP_TOTAL_BITS)
  ) u_argmax (
    .clk       (clk),
    .reset     (reset),
    .start     (am_start),
    .start_val (layer_out[0]),
    .scores    (out_scores),
    .done      (am_done),
    .best_idx  (am_best_idx)
  );

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  localparam int NF = 4;
  localparam int W  = 16;
  localparam int NC = 3;
  localparam int NL = 2;
  localparam int TO = 16;
  localparam int D  = 5;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_STALE  = 1;
  localparam int MODE_NEVER  = 2;

  typedef logic [NF-1:0][W-1:0] xvec_t;
  typedef logic [NC-1:0][W-1:0] ovec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   out_ready = 1'b0;
  logic   layer_done = 1'b0;
  xvec_t  in_x = '0;
  ovec_t  layer_out = '0;

  logic        in_ready, out_valid, error, busy, layer_start;
  ovec_t       out_scores;
  logic [1:0]  out_class;
  logic [0:0]  layer_sel;
  xvec_t       layer_x;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  mlp_layer_sequencer #(
    .NUM_FEATURES   (NF),
    .FP_TOTAL_BITS  (W),
    .FP_FRAC_BITS   (8),
    .NUM_CLASSES    (NC),
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_scores  (out_scores),
    .out_class   (out_class),
    .error       (error),
    .busy        (busy),
    .layer_start (layer_start),
    .layer_sel   (layer_sel),
    .layer_x     (layer_x),
    .layer_out   (layer_out),
    .layer_done  (layer_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- datapath responder ----------------
  // Sees layer_start on the START cycle (cycle s) and raises done in cycle s+D.
  int    dp_mode = MODE_NORMAL;
  int    dcnt = -1000;
  int    start_cnt = 0;
  xvec_t snap_x [2];
  ovec_t l0_out, l1_out;

  always @(negedge clk) begin
    if (layer_start === 1'b1) begin
      snap_x[layer_sel] = layer_x;
      start_cnt = start_cnt + 1;
      dcnt = 0;
      if (dp_mode != MODE_STALE) layer_done = 1'b0;
    end else begin
      dcnt = dcnt + 1;
      if (dp_mode == MODE_STALE && dcnt == 2) layer_done = 1'b0;
      if (dp_mode != MODE_NEVER && dcnt == D) begin
        layer_out  = (layer_sel == 1'b1) ? l1_out : l0_out;
        layer_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input xvec_t x, output int t);
    in_x = x;
    in_valid = 1'b1;
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_x = {16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF};
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_valid(output int c);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_wait actual=%b required=1 within 100 cycles", out_valid);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready actual=%b required=0", in_ready);
    end
    checks++;
    if ({out_valid, error, busy, layer_start} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=0000", {out_valid, error, busy, layer_start});
    end
    checks++;
    if (layer_x !== '0 || layer_sel !== '0 || out_scores !== '0 || out_class !== '0) begin
      failures++;
      $display("FAIL reset_data actual x=%h sel=%h sc=%h cls=%h required=0", layer_x, layer_sel, out_scores, out_class);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
      failures++; $display("FAIL post_reset_idle actual rdy=%b st=%0d required rdy=1 st=0", in_ready, dbg_state);
    end
  endtask

  task automatic test_nominal();
    xvec_t x, exp_x1;
    ovec_t exp_sc;
    int t, c;
    x      = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    exp_x1 = {16'h0000, 16'h0080, 16'h0000, 16'h0100};
    exp_sc = {16'h0300, 16'h0300, 16'h0040};
    l0_out = {16'h0080, 16'hFE00, 16'h0100};
    l1_out = {16'h0300, 16'h0300, 16'h0040};
    dp_mode = MODE_NORMAL;
    start_cnt = 0;
    accept(x, t);
    checks++;
    if (busy !== 1'b1 || layer_start !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL nom_start actual busy=%b start=%b rdy=%b required 1 1 0", busy, layer_start, in_ready);
    end
    wait_valid(c);
    checks++;
    if (c - t != 17) begin
      failures++; $display("FAIL nom_latency actual=%0d required=17", c - t);
    end
    checks++;
    if (snap_x[0] !== x) begin
      failures++; $display("FAIL nom_layer0_x actual=%h required=%h", snap_x[0], x);
    end
    checks++;
    if (snap_x[1] !== exp_x1) begin
      failures++; $display("FAIL nom_layer1_x actual=%h required=%h", snap_x[1], exp_x1);
    end
    checks++;
    if (out_class !== 2'd1) begin
      failures++; $display("FAIL nom_class actual=%0d required=1", out_class);
    end
    checks++;
    if (out_scores !== exp_sc) begin
      failures++; $display("FAIL nom_scores actual=%h required=%h", out_scores, exp_sc);
    end
    checks++;
    if (start_cnt != 2) begin
      failures++; $display("FAIL nom_start_pulses actual=%0d required=2", start_cnt);
    end
  endtask

  task automatic test_backpressure();
    ovec_t exp_sc;
    exp_sc = {16'h0300, 16'h0300, 16'h0040};
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_scores !== exp_sc || out_class !== 2'd1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d actual v=%b sc=%h cls=%0d rdy=%b required v=1 sc=%h cls=1 rdy=0",
                 i, out_valid, out_scores, out_class, in_ready, exp_sc);
      end
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL bp_release actual v=%b rdy=%b busy=%b st=%0d required 0 1 0 0", out_valid, in_ready, busy, dbg_state);
    end
  endtask

  task automatic test_stale_done();
    xvec_t x;
    int t, c;
    x = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    l0_out = {16'h0080, 16'hFE00, 16'h0100};
    l1_out = {16'h0200, 16'h0100, 16'h0200};
    dp_mode = MODE_STALE;
    layer_done = 1'b1;
    accept(x, t);
    wait_until(t + 3);
    checks++;
    if (dbg_state !== WAIT || layer_sel !== 1'b0) begin
      failures++; $display("FAIL stale_no_early_capture actual st=%0d sel=%0d required st=2 sel=0", dbg_state, layer_sel);
    end
    wait_valid(c);
    checks++;
    if (c - t != 17) begin
      failures++; $display("FAIL stale_latency actual=%0d required=17", c - t);
    end
    checks++;
    if (out_class !== 2'd0) begin
      failures++; $display("FAIL stale_class_tie actual=%0d required=0", out_class);
    end
    drain();
    dp_mode = MODE_NORMAL;
  endtask

  task automatic test_timeout();
    xvec_t x;
    int t, c;
    x = {16'h0010, 16'h0020, 16'h0030, 16'h0040};
    dp_mode = MODE_NEVER;
    layer_done = 1'b0;
    accept(x, t);
    wait_until(t + 17);
    checks++;
    if (dbg_state !== WAIT || error !== 1'b0) begin
      failures++; $display("FAIL to_before actual st=%0d err=%b required st=2 err=0", dbg_state, error);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || dbg_state !== ERROR) begin
      failures++;
      $display("FAIL to_error actual err=%b rdy=%b busy=%b v=%b st=%0d required 1 1 0 0 6",
               error, in_ready, busy, out_valid, dbg_state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      failures++; $display("FAIL to_sticky actual=%b required=1", error);
    end
    dp_mode = MODE_NORMAL;
    l0_out = {16'h0080, 16'hFE00, 16'h0100};
    l1_out = {16'h0300, 16'h0300, 16'h0040};
    accept(x, t);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || layer_sel !== 1'b0) begin
      failures++; $display("FAIL to_recover_accept actual err=%b busy=%b sel=%0d required 0 1 0", error, busy, layer_sel);
    end
    wait_valid(c);
    checks++;
    if (c - t != 17 || out_class !== 2'd1) begin
      failures++; $display("FAIL to_recover_run actual lat=%0d cls=%0d required lat=17 cls=1", c - t, out_class);
    end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    xvec_t x;
    int t, bad;
    x = {16'h0101, 16'h0202, 16'h0303, 16'h0404};
    dp_mode = MODE_NORMAL;
    accept(x, t);
    wait_until(t + 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, error, busy, layer_start, in_ready} !== 5'b00000 ||
        layer_sel !== '0 || layer_x !== '0 || out_scores !== '0 || out_class !== '0) begin
      failures++;
      $display("FAIL async_reset actual v=%b e=%b b=%b st=%b rdy=%b sel=%0d x=%h sc=%h cls=%0d required all 0",
               out_valid, error, busy, layer_start, in_ready, layer_sel, layer_x, out_scores, out_class);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL post_abort_idle actual bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_negative_scores();
    xvec_t x;
    ovec_t exp_sc;
    int t, c;
    x = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    exp_sc = {16'hFF80, 16'hFE00, 16'hFF00};
    l0_out = {16'h0080, 16'hFE00, 16'h0100};
    l1_out = {16'hFF80, 16'hFE00, 16'hFF00};
    dp_mode = MODE_NORMAL;
    accept(x, t);
    wait_valid(c);
    checks++;
    if (out_class !== 2'd2) begin
      failures++; $display("FAIL neg_class actual=%0d required=2", out_class);
    end
    checks++;
    if (out_scores !== exp_sc) begin
      failures++; $display("FAIL neg_scores_raw actual=%h required=%h", out_scores, exp_sc);
    end
    checks++;
    if (c - t != 17) begin
      failures++; $display("FAIL neg_latency actual=%0d required=17", c - t);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_stale_done();
    test_timeout();
    test_reset_mid_wait();
    test_negative_scores();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
